// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU MAC path.
// Holds the accumulator FSM states and width helper.
package alu_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  function automatic int calc_acc_width(
    input int size,
    input int count
  );
    return 2 * size + $clog2(count);
  endfunction

endpackage

// File: rtl/mult_accumulator_if.sv
// Product-in / result-out handshake bundle for the
// multiply-accumulate block.
interface mult_accumulator_if #(
  parameter int SIZE      = 8,
  parameter int ACC_WIDTH = 18,
  parameter int CW        = 3
);

  logic [2*SIZE-1:0]    prod_data;
  logic                 prod_narrow_ovf;
  logic                 prod_valid;
  logic                 prod_ready;
  logic                 acc_clear;
  logic [ACC_WIDTH-1:0] res_data;
  logic                 res_narrow_ovf;
  logic                 res_acc_ovf;
  logic                 res_valid;
  logic                 res_ready;
  logic [CW-1:0]        batch_count;

  modport slave (
    input  prod_data,
    input  prod_narrow_ovf,
    input  prod_valid,
    output prod_ready,
    input  acc_clear,
    output res_data,
    output res_narrow_ovf,
    output res_acc_ovf,
    output res_valid,
    input  res_ready,
    output batch_count
  );

  modport master (
    output prod_data,
    output prod_narrow_ovf,
    output prod_valid,
    input  prod_ready,
    output acc_clear,
    input  res_data,
    input  res_narrow_ovf,
    input  res_acc_ovf,
    input  res_valid,
    output res_ready,
    input  batch_count
  );

endinterface

// File: rtl/mult_accumulator_adder.sv
// Unsigned W-bit adder with carry-out as overflow.
// Used as the accumulate stage adder.
module mult_accumulator_adder #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  assign {ovf, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_accumulator.sv
// Sums COUNT multiplier products per batch and hands
// the result plus sticky overflow flags downstream.
module mult_accumulator
  import alu_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = calc_acc_width(SIZE, COUNT)
) (
  input logic              clk,
  input logic              rst_n,
  mult_accumulator_if.slave bus
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  acc_state_t           state;
  acc_state_t           state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] res_data;
  logic [CW-1:0]        count;
  logic                 narrow;
  logic                 acc_ovf;
  logic                 carry;

  logic ready;
  logic accept;
  logic do_clear;
  logic do_step;
  logic do_last;
  logic do_release;

  mult_accumulator_adder #(
    .W (ACC_WIDTH)
  ) u_adder (
    .a   (acc),
    .b   (ACC_WIDTH'(bus.prod_data)),
    .sum (sum),
    .ovf (carry)
  );

  assign ready      = (state == ACCUM) && !bus.acc_clear;
  assign accept     = bus.prod_valid && ready;
  assign do_clear   = bus.acc_clear;
  assign do_step    = accept && (count != LAST);
  assign do_last    = accept && (count == LAST);
  assign do_release = (state == HOLD) && bus.res_ready
                      && !bus.acc_clear;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      do_clear:   state_nxt = ACCUM;
      do_last:    state_nxt = HOLD;
      do_release: state_nxt = ACCUM;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Clear and release both return to an empty batch;
  // res_data is untouched so it keeps the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      narrow   <= 1'b0;
      acc_ovf  <= 1'b0;
      res_data <= '0;
    end else begin
      unique case (1'b1)
        do_clear, do_release: begin
          acc     <= '0;
          count   <= '0;
          narrow  <= 1'b0;
          acc_ovf <= 1'b0;
        end
        do_step: begin
          acc     <= sum;
          count   <= count + 1'b1;
          narrow  <= narrow | bus.prod_narrow_ovf;
          acc_ovf <= acc_ovf | carry;
        end
        do_last: begin
          acc      <= sum;
          count    <= count + 1'b1;
          narrow   <= narrow | bus.prod_narrow_ovf;
          acc_ovf  <= acc_ovf | carry;
          res_data <= sum;
        end
        default: ;
      endcase
    end
  end

  assign bus.prod_ready     = ready;
  assign bus.res_valid      = (state == HOLD);
  assign bus.res_data       = res_data;
  assign bus.res_narrow_ovf = narrow;
  assign bus.res_acc_ovf    = acc_ovf;
  assign bus.batch_count    = count;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench for mult_accumulator: directed
// cases plus randomized traffic against a sum model.
module tb_mult_accumulator;

  localparam int SIZE = 8;
  localparam int CNT  = 4;
  localparam int AW   = 18;
  localparam int CW   = 3;
  localparam int BAW  = 16;
  localparam int BCW  = 2;

  typedef struct {
    longint data;
    bit     n;
    bit     a;
  } exp_t;

  typedef struct {
    longint d;
    bit     n;
  } prod_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_accumulator_if #(
    .SIZE(SIZE), .ACC_WIDTH(AW), .CW(CW)
  ) pa ();
  mult_accumulator_if #(
    .SIZE(SIZE), .ACC_WIDTH(BAW), .CW(BCW)
  ) pb ();

  mult_accumulator #(
    .SIZE(SIZE), .COUNT(CNT)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pa.slave)
  );

  mult_accumulator #(
    .SIZE(SIZE), .COUNT(2), .ACC_WIDTH(BAW)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pb.slave)
  );

  int    checks = 0;
  int    passed = 0;
  exp_t  sbq[$];
  prod_t batch[$];
  bit    hold = 1'b0;

  task automatic chk(
    input string  name,
    input longint got,
    input longint exp
  );
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, got, exp);
  endtask

  // Reference: a batch result is the plain integer
  // sum; any wrap past 2^AW sets the acc flag.
  task automatic close_batch();
    exp_t   e;
    longint tot = 0;
    bit     nf = 1'b0;
    foreach (batch[i]) begin
      tot += batch[i].d;
      nf  |= batch[i].n;
    end
    e.data = tot % (longint'(1) << AW);
    e.n    = nf;
    e.a    = (tot >= (longint'(1) << AW));
    sbq.push_back(e);
    batch.delete();
    hold = 1'b1;
  endtask

  task automatic a_cyc(
    input bit          v,
    input logic [15:0] d,
    input bit          n,
    input bit          rr,
    input bit          clr
  );
    bit rdy;
    @(posedge clk);
    #1;
    pa.prod_valid      = v;
    pa.prod_data       = d;
    pa.prod_narrow_ovf = n;
    pa.res_ready       = rr;
    pa.acc_clear       = clr;
    @(negedge clk);
    rdy = !hold && !clr;
    chk("prod_ready", pa.prod_ready, rdy);
    chk("res_valid", pa.res_valid, hold);
    chk("batch_count", pa.batch_count,
        hold ? CNT : batch.size());
    if (clr) begin
      batch.delete();
      hold = 1'b0;
    end else if (hold) begin
      if (rr) hold = 1'b0;
    end else if (v) begin
      batch.push_back('{d: d, n: n});
      if (batch.size() == CNT) close_batch();
    end
  endtask

  task automatic b_cyc(
    input bit          v,
    input logic [15:0] d,
    input bit          rr
  );
    @(posedge clk);
    #1;
    pb.prod_valid      = v;
    pb.prod_data       = d;
    pb.prod_narrow_ovf = (d > 16'd255);
    pb.res_ready       = rr;
    pb.acc_clear       = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: whenever a result is presented, check it
  // against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && pa.res_valid) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 1, 0);
        end else begin
          chk("sb_data", pa.res_data, sbq[0].data);
          chk("sb_narrow", pa.res_narrow_ovf, sbq[0].n);
          chk("sb_accovf", pa.res_acc_ovf, sbq[0].a);
          if (pa.res_ready || pa.acc_clear)
            void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    pa.prod_valid = 0; pa.prod_data = 0;
    pa.prod_narrow_ovf = 0; pa.res_ready = 0;
    pa.acc_clear = 0;
    pb.prod_valid = 0; pb.prod_data = 0;
    pb.prod_narrow_ovf = 0; pb.res_ready = 0;
    pb.acc_clear = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", pa.res_valid, 0);
    chk("rst_data", pa.res_data, 0);
    chk("rst_count", pa.batch_count, 0);
    chk("rst_narrow", pa.res_narrow_ovf, 0);
    chk("rst_accovf", pa.res_acc_ovf, 0);
    chk("rst_ready", pa.prod_ready, 1);
    chk("rst_ready_b", pb.prod_ready, 1);

    // wrap case on the narrow instance
    b_cyc(1, 16'd65025, 1);
    b_cyc(1, 16'd65025, 1);
    b_cyc(0, 16'd0, 1);
    chk("wrap_valid", pb.res_valid, 1);
    chk("wrap_data", pb.res_data, 64514);
    chk("wrap_accovf", pb.res_acc_ovf, 1);
    b_cyc(1, 16'd1, 1);
    b_cyc(1, 16'd1, 1);
    b_cyc(0, 16'd0, 1);
    chk("nowrap_valid", pb.res_valid, 1);
    chk("nowrap_data", pb.res_data, 2);
    chk("nowrap_accovf", pb.res_acc_ovf, 0);
    b_cyc(0, 16'd0, 1);

    // back-to-back batch
    a_cyc(1, 16'd15, 0, 1, 0);
    a_cyc(1, 16'd40000, 1, 1, 0);
    a_cyc(1, 16'd65025, 1, 1, 0);
    a_cyc(1, 16'd1, 0, 1, 0);
    a_cyc(1, 16'd7, 0, 1, 0);
    chk("b2b_data", pa.res_data, 105041);
    a_cyc(0, 16'd0, 0, 1, 1);

    // backpressure then release
    for (int i = 0; i < 4; i++)
      a_cyc(1, 16'(1000 * (i + 1)), 0, 0, 0);
    for (int i = 0; i < 5; i++)
      a_cyc(1, 16'd9, 0, 0, 0);
    a_cyc(1, 16'd9, 0, 1, 0);
    a_cyc(1, 16'd5, 0, 0, 0);
    a_cyc(0, 16'd0, 0, 0, 1);

    // abort mid-batch
    a_cyc(1, 16'd100, 0, 1, 0);
    a_cyc(1, 16'd200, 0, 1, 0);
    a_cyc(1, 16'd300, 0, 1, 1);
    for (int i = 1; i <= 4; i++)
      a_cyc(1, 16'(i), 0, 1, 0);
    a_cyc(0, 16'd0, 0, 1, 0);
    chk("abort_data", pa.res_data, 10);

    // async reset while a result is held
    for (int i = 0; i < 4; i++)
      a_cyc(1, 16'd50, 0, 0, 0);
    a_cyc(0, 16'd0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async_valid", pa.res_valid, 0);
    sbq.delete();
    batch.delete();
    hold = 1'b0;
    #1 rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      a_cyc(($urandom % 4) != 0,
            16'($urandom),
            1'($urandom),
            1'($urandom),
            ($urandom % 25) == 0);
    end
    repeat (3) a_cyc(0, 16'd0, 0, 1, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
